// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-through, no-write-allocate data cache responder
module dcache_responder #(
  parameter int data_size  = 32,
  parameter int mem_size   = 16,
  parameter int index_size = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [mem_size-1:0]  DC_Address,
  input  logic                 DC_Read_enable,
  input  logic                 DC_Write_enable,
  input  logic [data_size-1:0] DC_Write_Data,
  output logic [data_size-1:0] DC_Read_Data,
  output logic                 DC_stall,
  output logic [mem_size-1:0]  Mem_Address,
  output logic                 Mem_Read,
  output logic                 Mem_Write,
  output logic [data_size-1:0] Mem_Write_Data,
  input  logic [data_size-1:0] Mem_Read_Data,
  input  logic                 Mem_ready,
  output logic [15:0]          Hit_count,
  output logic [15:0]          Miss_count
);
  localparam int lines    = 1 << index_size;
  localparam int tag_size = mem_size - index_size;
  typedef enum logic [1:0] {IDLE, RMISS, WMEM, DONE} state_t;
  state_t state, state_n;
  logic [lines-1:0]     valid;
  logic [tag_size-1:0]  tags [lines];
  logic [data_size-1:0] data [lines];
  logic [index_size-1:0] idx, fidx;
  logic hit, store, load_hit, load_miss, fill;
  assign idx       = DC_Address[index_size-1:0];
  assign fidx      = Mem_Address[index_size-1:0];
  assign hit       = valid[idx] && tags[idx] == DC_Address[mem_size-1:index_size];
  assign store     = state == IDLE && DC_Write_enable;
  assign load_hit  = state == IDLE && !DC_Write_enable && DC_Read_enable && hit;
  assign load_miss = state == IDLE && !DC_Write_enable && DC_Read_enable && !hit;
  assign fill      = state == RMISS && Mem_ready;
  assign Mem_Read     = state == RMISS;
  assign Mem_Write    = state == WMEM;
  assign DC_Read_Data = data[idx];
  always_comb begin
    state_n  = state;
    DC_stall = store || load_miss || state == RMISS || state == WMEM;
    state_n  = store ? WMEM :
               load_miss ? RMISS :
               (state inside {RMISS, WMEM}) && Mem_ready ? DONE :
               state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      valid          <= '0;
      Mem_Address    <= '0;
      Mem_Write_Data <= '0;
      Hit_count      <= '0;
      Miss_count     <= '0;
    end else begin
      state <= state_n;
      if (fill) valid[fidx] <= 1'b1;
      if (store || load_miss) Mem_Address <= DC_Address;
      if (store) Mem_Write_Data <= DC_Write_Data;
      if (load_hit && Hit_count != 16'hFFFF) Hit_count <= Hit_count + 16'd1;
      if (load_miss && Miss_count != 16'hFFFF) Miss_count <= Miss_count + 16'd1;
    end
  end
  // arrays are never cleared; valid alone gates hits after reset
  always_ff @(posedge clk) begin
    if (store && hit) data[idx] <= DC_Write_Data;
    else if (fill) begin
      data[fidx] <= Mem_Read_Data;
      tags[fidx] <= Mem_Address[mem_size-1:index_size];
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: table-driven per-cycle checks plus reset-mid-miss and counter saturation
module tb_dcache_responder;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] addr = '0;
  logic        rd = 1'b0, wr = 1'b0, rdy = 1'b0;
  logic [31:0] wd = '0, mrd = '0;
  logic [31:0] rdata, mwd;
  logic [15:0] maddr, hits, misses;
  logic        stall, mr, mw;
  int checks = 0, errors = 0;

  dcache_responder dut (
    .clk(clk), .rst(rst), .DC_Address(addr), .DC_Read_enable(rd), .DC_Write_enable(wr),
    .DC_Write_Data(wd), .DC_Read_Data(rdata), .DC_stall(stall), .Mem_Address(maddr),
    .Mem_Read(mr), .Mem_Write(mw), .Mem_Write_Data(mwd), .Mem_Read_Data(mrd),
    .Mem_ready(rdy), .Hit_count(hits), .Miss_count(misses)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] mrd;
    logic        stall, mr, mw, crd;
    logic [31:0] rdata;
    logic        cma;
    logic [15:0] maddr;
    logic [31:0] mwd;
    logic [15:0] hits, misses;
  } vec_t;
  vec_t tbl [30];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  initial begin
    tbl = '{
      '{0,0,16'h0000,32'h0,0,32'h0,        0,0,0, 0,32'h0,        0,16'h0000,32'h0,        16'd0,16'd0},
      '{1,0,16'h0040,32'h0,0,32'h0,        1,0,0, 0,32'h0,        0,16'h0000,32'h0,        16'd0,16'd0},
      '{1,0,16'h0040,32'h0,0,32'h0,        1,1,0, 0,32'h0,        1,16'h0040,32'h0,        16'd0,16'd1},
      '{1,0,16'h0040,32'h0,0,32'h0,        1,1,0, 0,32'h0,        1,16'h0040,32'h0,        16'd0,16'd1},
      '{1,0,16'h0040,32'h0,1,32'hDEADBEEF, 1,1,0, 0,32'h0,        1,16'h0040,32'h0,        16'd0,16'd1},
      '{1,0,16'h0040,32'h0,0,32'h0,        0,0,0, 1,32'hDEADBEEF, 0,16'h0000,32'h0,        16'd0,16'd1},
      '{1,0,16'h0040,32'h0,0,32'h0,        0,0,0, 1,32'hDEADBEEF, 0,16'h0000,32'h0,        16'd0,16'd1},
      '{0,1,16'h0040,32'h12345678,1,32'h0, 1,0,0, 0,32'h0,        0,16'h0000,32'h0,        16'd1,16'd1},
      '{0,1,16'h0040,32'h12345678,1,32'h0, 1,0,1, 0,32'h0,        1,16'h0040,32'h12345678, 16'd1,16'd1},
      '{0,1,16'h0040,32'h12345678,0,32'h0, 0,0,0, 1,32'h12345678, 0,16'h0000,32'h0,        16'd1,16'd1},
      '{1,0,16'h0040,32'h0,0,32'h0,        0,0,0, 1,32'h12345678, 0,16'h0000,32'h0,        16'd1,16'd1},
      '{0,1,16'h0081,32'hCAFEF00D,0,32'h0, 1,0,0, 0,32'h0,        0,16'h0000,32'h0,        16'd2,16'd1},
      '{0,1,16'h0081,32'hCAFEF00D,0,32'h0, 1,0,1, 0,32'h0,        1,16'h0081,32'hCAFEF00D, 16'd2,16'd1},
      '{0,1,16'h0081,32'hCAFEF00D,1,32'h0, 1,0,1, 0,32'h0,        1,16'h0081,32'hCAFEF00D, 16'd2,16'd1},
      '{0,1,16'h0081,32'hCAFEF00D,0,32'h0, 0,0,0, 0,32'h0,        0,16'h0000,32'h0,        16'd2,16'd1},
      '{1,0,16'h0081,32'h0,0,32'h0,        1,0,0, 0,32'h0,        0,16'h0000,32'h0,        16'd2,16'd1},
      '{1,0,16'h0081,32'h0,1,32'h0BADF00D, 1,1,0, 0,32'h0,        1,16'h0081,32'hCAFEF00D, 16'd2,16'd2},
      '{1,0,16'h0081,32'h0,0,32'h0,        0,0,0, 1,32'h0BADF00D, 0,16'h0000,32'h0,        16'd2,16'd2},
      '{1,0,16'h0080,32'h0,0,32'h0,        1,0,0, 0,32'h0,        0,16'h0000,32'h0,        16'd2,16'd2},
      '{1,0,16'h0080,32'h0,1,32'h80808080, 1,1,0, 0,32'h0,        1,16'h0080,32'hCAFEF00D, 16'd2,16'd3},
      '{1,0,16'h0080,32'h0,0,32'h0,        0,0,0, 1,32'h80808080, 0,16'h0000,32'h0,        16'd2,16'd3},
      '{1,0,16'h0040,32'h0,0,32'h0,        1,0,0, 0,32'h0,        0,16'h0000,32'h0,        16'd2,16'd3},
      '{1,0,16'h0040,32'h0,1,32'h40404040, 1,1,0, 0,32'h0,        1,16'h0040,32'hCAFEF00D, 16'd2,16'd4},
      '{1,0,16'h0040,32'h0,0,32'h0,        0,0,0, 1,32'h40404040, 0,16'h0000,32'h0,        16'd2,16'd4},
      '{1,0,16'h0040,32'h0,0,32'h0,        0,0,0, 1,32'h40404040, 0,16'h0000,32'h0,        16'd2,16'd4},
      '{0,0,16'h0040,32'h0,0,32'h0,        0,0,0, 0,32'h0,        0,16'h0000,32'h0,        16'd3,16'd4},
      '{1,1,16'h0040,32'h55555555,0,32'h0, 1,0,0, 0,32'h0,        0,16'h0000,32'h0,        16'd3,16'd4},
      '{1,1,16'h0040,32'h55555555,1,32'h0, 1,0,1, 0,32'h0,        1,16'h0040,32'h55555555, 16'd3,16'd4},
      '{1,1,16'h0040,32'h55555555,0,32'h0, 0,0,0, 1,32'h55555555, 0,16'h0000,32'h0,        16'd3,16'd4},
      '{0,0,16'h0040,32'h0,0,32'h0,        0,0,0, 0,32'h0,        0,16'h0000,32'h0,        16'd3,16'd4}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset mem_addr", 32'(maddr), 32'd0);
    chk("reset mem_wdata", mwd, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      rd = tbl[i].rd; wr = tbl[i].wr; addr = tbl[i].addr; wd = tbl[i].wd;
      rdy = tbl[i].rdy; mrd = tbl[i].mrd;
      @(negedge clk);
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(tbl[i].stall));
      chk($sformatf("v%0d mem_read", i), 32'(mr), 32'(tbl[i].mr));
      chk($sformatf("v%0d mem_write", i), 32'(mw), 32'(tbl[i].mw));
      chk($sformatf("v%0d hit_count", i), 32'(hits), 32'(tbl[i].hits));
      chk($sformatf("v%0d miss_count", i), 32'(misses), 32'(tbl[i].misses));
      if (tbl[i].crd) chk($sformatf("v%0d read_data", i), rdata, tbl[i].rdata);
      if (tbl[i].cma) begin
        chk($sformatf("v%0d mem_addr", i), 32'(maddr), 32'(tbl[i].maddr));
        chk($sformatf("v%0d mem_wdata", i), mwd, tbl[i].mwd);
      end
    end
    // reset while a read miss is outstanding
    @(posedge clk);
    #1;
    rd = 1'b1; wr = 1'b0; addr = 16'h0100; rdy = 1'b0;
    @(negedge clk);
    chk("rst seq miss stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    chk("rst seq mem_read before", 32'(mr), 32'd1);
    #2;
    rst = 1'b1; rd = 1'b0;
    #1;
    chk("rst seq mem_read async", 32'(mr), 32'd0);
    chk("rst seq mem_write async", 32'(mw), 32'd0);
    chk("rst seq mem_addr", 32'(maddr), 32'd0);
    chk("rst seq hit_count", 32'(hits), 32'd0);
    chk("rst seq miss_count", 32'(misses), 32'd0);
    chk("rst seq stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0; rd = 1'b1; addr = 16'h0040;
    #1;
    chk("rst seq reload misses", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    chk("rst seq miss counted", 32'(misses), 32'd1);
    rdy = 1'b1; mrd = 32'h00000077;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    chk("rst seq done stall", 32'(stall), 32'd0);
    chk("rst seq done data", rdata, 32'h00000077);
    // sustained load hits saturate the hit counter
    repeat (70000) @(posedge clk);
    #1;
    chk("sat stall", 32'(stall), 32'd0);
    chk("sat hit_count", 32'(hits), 32'h0000FFFF);
    chk("sat miss_count", 32'(misses), 32'd1);
    chk("sat read_data", rdata, 32'h00000077);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
